// File: rtl/bus_pkg.sv
// Shared types and constants for the tile memory arbiter.
package bus_pkg;

    // Index of a bus master (two masters share the data memory)
    typedef logic [0:0] master_idx_t;

    // Arbiter operating mode: normal round-robin or debug-locked
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_t;

    localparam master_idx_t M_CORE = 1'b0;
    localparam master_idx_t M_DBG  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant. On a tie the master that was
// not granted most recently wins; mask_m0 removes the core from contention.
module rr_arb2
    import bus_pkg::*;
(
    input  logic [1:0]  valid,
    input  master_idx_t last_grant,
    input  logic        mask_m0,
    output logic [1:0]  grant
);

    logic [1:0] eligible_s;

    // Pick at most one eligible master, alternating on contention
    always_comb begin
        eligible_s = {valid[1], valid[0] & ~mask_m0};
        grant      = 2'b00;
        case (eligible_s)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant == M_CORE) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the tile's single-ported synchronous-read data memory between the
// core load/store port (m0) and the debug/loader port (m1). Grants are
// combinational; responses return one cycle later to the issuing master.
module mem_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wmask,
    output logic                    m0_resp_valid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wmask,
    output logic                    m1_resp_valid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    input  logic                    m1_lock,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    core_stall
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    arb_state_t  state_r;
    master_idx_t last_grant_r;
    master_idx_t resp_owner_r;
    logic        resp_pend_r;

    logic [1:0]  raw_grant_s;
    logic [1:0]  grant_s;
    logic        mask_m0_s;

    // Core is locked out only while locked and m1 still holds the lock;
    // the cycle the lock drops is arbitrated normally.
    assign mask_m0_s = (state_r == LOCK1) & m1_lock;

    rr_arb2 u_rr_arb2 (
        .valid      ({m1_req_valid, m0_req_valid}),
        .last_grant (last_grant_r),
        .mask_m0    (mask_m0_s),
        .grant      (raw_grant_s)
    );

    // Suppress every grant while reset is held
    always_comb begin
        if (rst) begin
            grant_s = 2'b00;
        end else begin
            grant_s = raw_grant_s;
        end
    end

    assign m0_req_ready = grant_s[0];
    assign m1_req_ready = grant_s[1];
    assign mem_en       = |grant_s;
    assign core_stall   = m0_req_valid & ~grant_s[0];

    // Route the granted master's request fields onto the memory port
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        mem_wmask = {MASK_WIDTH{1'b0}};
        case (grant_s)
            2'b01: begin
                mem_we    = m0_we;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_wmask = m0_we ? m0_wmask : {MASK_WIDTH{1'b0}};
            end
            2'b10: begin
                mem_we    = m1_we;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_wmask = m1_we ? m1_wmask : {MASK_WIDTH{1'b0}};
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = {ADDR_WIDTH{1'b0}};
                mem_wdata = {DATA_WIDTH{1'b0}};
                mem_wmask = {MASK_WIDTH{1'b0}};
            end
        endcase
    end

    // Lock FSM, round-robin history and response bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ARB;
            last_grant_r <= M_DBG;
            resp_owner_r <= M_CORE;
            resp_pend_r  <= 1'b0;
        end else begin
            case (state_r)
                ARB: begin
                    if (grant_s[1] && m1_lock) begin
                        state_r <= LOCK1;
                    end else begin
                        state_r <= ARB;
                    end
                end
                LOCK1: begin
                    if (!m1_lock) begin
                        state_r <= ARB;
                    end else begin
                        state_r <= LOCK1;
                    end
                end
                default: state_r <= ARB;
            endcase

            if (mem_en) begin
                last_grant_r <= grant_s[1] ? M_DBG : M_CORE;
                resp_owner_r <= grant_s[1] ? M_DBG : M_CORE;
            end else begin
                last_grant_r <= last_grant_r;
                resp_owner_r <= resp_owner_r;
            end
            resp_pend_r <= mem_en;
        end
    end

    assign m0_resp_valid = resp_pend_r & (resp_owner_r == M_CORE);
    assign m1_resp_valid = resp_pend_r & (resp_owner_r == M_DBG);
    assign m0_rdata      = mem_rdata;
    assign m1_rdata      = mem_rdata;

endmodule
